// File: rtl/posit_to_float_pipe.sv
// posit_to_float_pipe: 3-stage posit(N,ES) to IEEE-754 binary32 converter.
//   S1: sign and two's-complement magnitude, zero/NaR detection.
//   S2: regime run length k, exponent e, fraction; scale = k*2^ES + e.
//   S3: bias, round-to-nearest-even to 23 bits, saturation/underflow, packing.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   in_valid_i/in_ready_o  operand handshake, in_posit_i operand (N bits)
//   out_valid_o/out_ready_i result handshake
//   out_float_o            binary32 result
//   out_flags_o            {nar, inexact, underflow}
// Build option: define POSIT_TO_FLOAT_DENORM_EN to produce binary32 subnormals on
// underflow; otherwise underflowing values flush to a signed zero.
// All stages advance together when the output register is empty or being drained,
// so bubbles travel with the pipeline and a stalled result holds stable.
module posit_to_float_pipe #(
  parameter int unsigned N  = 32,
  parameter int unsigned ES = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] in_posit_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [31:0]  out_float_o,
  output logic [2:0]   out_flags_o
);

  // Width of the posit body below the sign bit.
  localparam int unsigned RW = N - 1;

  logic advance;

  // Stage 1 state.
  logic          s1_valid_q, s1_sign_q, s1_nar_q, s1_zero_q;
  logic [RW-1:0] s1_mag_q;
  logic          s1_nar_d, s1_zero_d;
  logic [RW-1:0] s1_mag_d;

  // Stage 2 state.
  logic              s2_valid_q, s2_sign_q, s2_nar_q, s2_zero_q;
  logic signed [9:0] s2_scale_q, s2_scale_d;
  logic [31:0]       s2_frac_q, s2_frac_d;

  // Stage 2 decode.
  logic              run_bit;
  logic [RW-1:0]     run_x;
  logic [5:0]        run_len;
  logic signed [9:0] k_s, e_s;
  logic [RW-1:0]     rest;
  logic [RW-1:0]     frac_top;

  // Stage 3 state and rounding.
  logic              out_valid_q;
  logic [31:0]       out_float_q, res_float;
  logic [2:0]        out_flags_q, res_flags;
  logic signed [9:0] biased;
  logic [22:0]       mant;
  logic              guard, sticky;
  logic [30:0]       norm_sum;
`ifdef POSIT_TO_FLOAT_DENORM_EN
  logic signed [9:0] sh_amt;
  logic [5:0]        sh_cap;
  logic [65:0]       sub_wide;
  logic [22:0]       sub_mant;
  logic              sub_g, sub_s;
  logic [30:0]       sub_sum;
`endif

  assign advance     = !out_valid_q || out_ready_i;
  assign in_ready_o  = advance;
  assign out_valid_o = out_valid_q;
  assign out_float_o = out_float_q;
  assign out_flags_o = out_flags_q;

  // ---------------------------------------------------------------- Stage 1
  // Only the low N-1 bits of the magnitude matter: for every legal non-NaR
  // operand the top bit of the magnitude is zero.
  always_comb begin
    s1_mag_d  = in_posit_i[N-1] ? (~in_posit_i[RW-1:0] + {{(RW-1){1'b0}}, 1'b1})
                                : in_posit_i[RW-1:0];
    s1_nar_d  = (in_posit_i == {1'b1, {RW{1'b0}}});
    s1_zero_d = (in_posit_i == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_nar_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_mag_q   <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid_i;
      s1_sign_q  <= in_posit_i[N-1];
      s1_nar_q   <= s1_nar_d;
      s1_zero_q  <= s1_zero_d;
      s1_mag_q   <= s1_mag_d;
    end
  end

  // ---------------------------------------------------------------- Stage 2
  always_comb begin
    run_bit = s1_mag_q[RW-1];
    // Leading-zero count of run_x equals the regime run length.
    run_x   = run_bit ? ~s1_mag_q : s1_mag_q;
    run_len = 6'(RW);
    for (int i = 0; i < int'(RW); i++) begin
      if (run_x[i]) run_len = 6'(int'(RW) - 1 - i);
    end
    k_s = run_bit ? ($signed({4'b0, run_len}) - 10'sd1) : -$signed({4'b0, run_len});
    // Drop regime and terminator; a regime filling the word leaves nothing.
    rest       = s1_mag_q << (run_len + 6'd1);
    // Truncated exponent bits read as zero because the shift fills with zeros.
    e_s        = $signed(10'(rest >> (RW - ES)));
    frac_top   = rest << ES;
    s2_frac_d  = {frac_top, {(33 - N){1'b0}}};
    s2_scale_d = (k_s <<< ES) + e_s;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_nar_q   <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_scale_q <= '0;
      s2_frac_q  <= '0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_nar_q   <= s1_nar_q;
      s2_zero_q  <= s1_zero_q;
      s2_scale_q <= s2_scale_d;
      s2_frac_q  <= s2_frac_d;
    end
  end

  // ---------------------------------------------------------------- Stage 3
  always_comb begin
    biased   = s2_scale_q + 10'sd127;
    mant     = s2_frac_q[31:9];
    guard    = s2_frac_q[8];
    sticky   = |s2_frac_q[7:0];
    // Adding the round bit across {exp, mant} carries into the exponent.
    norm_sum = {biased[7:0], mant} + 31'(guard && (sticky || mant[0]));
`ifdef POSIT_TO_FLOAT_DENORM_EN
    // Align 1.frac to the subnormal grid; a cap of 34 already pushes every
    // significand bit below the guard position into the sticky field.
    sh_amt   = 10'sd1 - biased;
    sh_cap   = (sh_amt > 10'sd34) ? 6'd34 : sh_amt[5:0];
    sub_wide = 66'({1'b1, s2_frac_q, 34'b0} >> sh_cap);
    sub_mant = sub_wide[65:43];
    sub_g    = sub_wide[42];
    sub_s    = |sub_wide[41:0];
    // A carry out of sub_mant yields the smallest normal encoding directly.
    sub_sum  = {8'b0, sub_mant} + 31'(sub_g && (sub_s || sub_mant[0]));
`endif
    res_float = '0;
    res_flags = '0;
    if (s2_nar_q) begin
      res_float = 32'h7FC0_0000;
      res_flags = 3'b100;
    end else if (s2_zero_q) begin
      res_float = '0;
      res_flags = 3'b000;
    end else if (biased <= 10'sd0) begin
`ifdef POSIT_TO_FLOAT_DENORM_EN
      res_float = {s2_sign_q, sub_sum};
      res_flags = {1'b0, sub_g || sub_s, 1'b1};
`else
      res_float = {s2_sign_q, 31'b0};
      res_flags = 3'b011;
`endif
    end else if (biased >= 10'sd255 || norm_sum[30:23] == 8'hFF) begin
      res_float = {s2_sign_q, 31'h7F7F_FFFF};
      res_flags = 3'b010;
    end else begin
      res_float = {s2_sign_q, norm_sum};
      res_flags = {1'b0, guard || sticky, 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_float_q <= '0;
      out_flags_q <= '0;
    end else if (advance) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_float_q <= res_float;
        out_flags_q <= res_flags;
      end
    end
  end

endmodule

// File: tb/tb_posit_to_float_pipe.sv
// tb_posit_to_float_pipe: directed self-checking bench for posit_to_float_pipe.
// Two instances share handshakes: dut (N=32, ES=2) and dut3 (N=32, ES=3).
module tb_posit_to_float_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [31:0] in_posit, in_posit3;
  logic        in_ready, in_ready3, out_valid, out_valid3;
  logic [31:0] out_float, out_float3;
  logic [2:0]  out_flags, out_flags3;

  int checks = 0;
  int errors = 0;

  logic [31:0] bp_in  [5];
  logic [31:0] bp_exp [5];
  int          sent, rcv;
  logic        stall_prev, acc_in, seen;
  logic [31:0] held_f;
  logic [2:0]  held_fl;

  always #5 clk = ~clk;

  posit_to_float_pipe #(.N(32), .ES(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_posit_i  (in_posit),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_float_o (out_float),
    .out_flags_o (out_flags)
  );

  posit_to_float_pipe #(.N(32), .ES(3)) dut3 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready3),
    .in_posit_i  (in_posit3),
    .out_valid_o (out_valid3),
    .out_ready_i (out_ready),
    .out_float_o (out_float3),
    .out_flags_o (out_flags3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One isolated transfer through both instances; starts and ends just after a rising edge.
  task automatic xfer(input string tag, input logic [31:0] p, input logic [31:0] p3,
                      input logic [31:0] ef, input logic [2:0] efl,
                      input logic [31:0] ef3, input logic [2:0] efl3);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_posit  = p;
    in_posit3 = p3;
    #1;
    chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd3);
    chk({tag, " float"}, out_float, ef);
    chk({tag, " flags"}, {29'b0, out_flags}, {29'b0, efl});
    chk({tag, " es3 float"}, out_float3, ef3);
    chk({tag, " es3 flags"}, {29'b0, out_flags3}, {29'b0, efl3});
    @(posedge clk); #1;
  endtask

  initial begin
    bp_in[0] = 32'h4000_0000; bp_exp[0] = 32'h3F80_0000;
    bp_in[1] = 32'hC000_0000; bp_exp[1] = 32'hBF80_0000;
    bp_in[2] = 32'h4800_0000; bp_exp[2] = 32'h4000_0000;
    bp_in[3] = 32'h4400_0000; bp_exp[3] = 32'h3FC0_0000;
    bp_in[4] = 32'h6000_0000; bp_exp[4] = 32'h4180_0000;

    // Reset state, with out_ready low to show in_ready is still high.
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_posit  = '0;
    in_posit3 = '0;
    #2;
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset out_float", out_float, 32'd0);
    chk("reset out_flags", {29'b0, out_flags}, 32'd0);
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: ES=2 operand/result, then ES=3 operand/result.
    xfer("one",     32'h4000_0000, 32'h4000_0000, 32'h3F80_0000, 3'b000, 32'h3F80_0000, 3'b000);
    xfer("neg one", 32'hC000_0000, 32'h7FFF_FFFF, 32'hBF80_0000, 3'b000, 32'h7F7F_FFFF, 3'b010);
    xfer("zero",    32'h0000_0000, 32'h8000_0001, 32'h0000_0000, 3'b000, 32'hFF7F_FFFF, 3'b010);
    xfer("nar",     32'h8000_0000, 32'h8000_0000, 32'h7FC0_0000, 3'b100, 32'h7FC0_0000, 3'b100);
    xfer("tie even", 32'h4000_0008, 32'h0000_0001, 32'h3F80_0000, 3'b010,
         32'h0000_0000, 3'b011);
`ifdef POSIT_TO_FLOAT_DENORM_EN
    xfer("tie odd", 32'h4000_0018, 32'h0000_3000, 32'h3F80_0002, 3'b010,
         32'h0002_0000, 3'b001);
`else
    xfer("tie odd", 32'h4000_0018, 32'h0000_3000, 32'h3F80_0002, 3'b010,
         32'h0000_0000, 3'b011);
`endif
    xfer("two",     32'h4800_0000, 32'hFFFF_FFFF, 32'h4000_0000, 3'b000, 32'h8000_0000, 3'b011);
    xfer("1.5",     32'h4400_0000, 32'h4000_0000, 32'h3FC0_0000, 3'b000, 32'h3F80_0000, 3'b000);
    xfer("-1.5",    32'hBC00_0000, 32'h4000_0000, 32'hBFC0_0000, 3'b000, 32'h3F80_0000, 3'b000);
    xfer("carry",   32'h47FF_FFFF, 32'h4000_0000, 32'h4000_0000, 3'b010, 32'h3F80_0000, 3'b000);
    xfer("maxpos",  32'h7FFF_FFFF, 32'h4000_0000, 32'h7B80_0000, 3'b000, 32'h3F80_0000, 3'b000);
    xfer("minpos",  32'h0000_0001, 32'h4000_0000, 32'h0380_0000, 3'b000, 32'h3F80_0000, 3'b000);
    xfer("k=1",     32'h6000_0000, 32'h4000_0000, 32'h4180_0000, 3'b000, 32'h3F80_0000, 3'b000);
    xfer("k=-1",    32'h2000_0000, 32'h4000_0000, 32'h3D80_0000, 3'b000, 32'h3F80_0000, 3'b000);

    // Backpressure: stall for 6 cycles, then drain with out_ready toggling.
    sent       = 0;
    rcv        = 0;
    stall_prev = 1'b0;
    held_f     = '0;
    held_fl    = '0;
    for (int cyc = 0; cyc < 40 && rcv < 5; cyc++) begin
      out_ready = (cyc < 6) ? 1'b0 : cyc[0];
      in_valid  = (sent < 5);
      in_posit  = bp_in[(sent < 5) ? sent : 0];
      #1;
      if (stall_prev) begin
        chk("bp hold float", out_float, held_f);
        chk("bp hold flags", {29'b0, out_flags}, {29'b0, held_fl});
      end
      if (cyc == 5) begin
        chk("bp accepts before stall", 32'(sent), 32'd3);
        chk("bp in_ready low", {31'b0, in_ready}, 32'd0);
      end
      acc_in = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk("bp order", out_float, bp_exp[rcv]);
        rcv++;
      end
      stall_prev = out_valid && !out_ready;
      held_f     = out_float;
      held_fl    = out_flags;
      @(posedge clk); #1;
      if (acc_in) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp result count", 32'(rcv), 32'd5);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("bp no duplicate", {31'b0, seen}, 32'd0);

    // Reset with three operands in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_posit = bp_in[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre-reset out_valid", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid reset out_float", out_float, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("no stale result", {31'b0, seen}, 32'd0);
    xfer("after reset", 32'hC000_0000, 32'h4000_0000, 32'hBF80_0000, 3'b000,
         32'h3F80_0000, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/posit_to_float_pipe.md
POSIT_TO_FLOAT_PIPE -- requirements
Module: posit_to_float_pipe

Interface
REQ-001 Parameter N, default 32: posit input width; legal range 8..32.
REQ-002 Parameter ES, default 2: posit exponent field width; legal range 0..3.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  in_posit holds a valid operand.
REQ-006 in_ready  output  1  block accepts the operand this cycle.
REQ-007 in_posit  input  N  posit operand (two's-complement encoding).
REQ-008 out_valid  output  1  out_float and out_flags are valid.
REQ-009 out_ready  input  1  consumer accepts the result this cycle.
REQ-010 out_float  output  32  IEEE-754 binary32 result.
REQ-011 out_flags  output  3  {nar, inexact, underflow}.

Function
REQ-012 The block SHALL be a 3-stage pipeline:
- S1: sign extraction and two's-complement magnitude.
- S2: regime run-length k, exponent e and fraction extraction; scale = k*2^ES + e.
- S3: bias (+127), round-to-nearest-even to 23 fraction bits, and packing.
REQ-013 Transfers: input on in_valid&&in_ready; output on out_valid&&out_ready.
REQ-014 advance = !out_valid || out_ready; in_ready SHALL equal advance; every stage shifts only when advance=1.
REQ-015 Latency: exactly 3 cycles from accept to out_valid with no stall; throughput 1 per cycle.
REQ-016 Results SHALL leave in acceptance order; none dropped or duplicated under any out_ready pattern.
REQ-017 Bubbles (stage valid=0) travel with the pipeline; they are not collapsed.
REQ-018 While out_valid=1 and out_ready=0, out_float and out_flags SHALL hold stable.
REQ-019 Zero posit -> 0x00000000, flags 000.
REQ-020 NaR (1 followed by N-1 zeros) -> 0x7FC00000, nar=1.
REQ-021 Nonzero values: sign = posit sign; float fraction = top 23 posit fraction bits, zero-padded when fewer.
REQ-022 Rounding: guard = next bit, sticky = OR of remaining bits; round up iff guard && (sticky || lsb); inexact = guard || sticky.
REQ-023 A rounding carry out of the mantissa SHALL increment the exponent.
REQ-024 Biased exponent >= 255 after rounding -> saturate to sign|0x7F7FFFFF with inexact=1; reachable only with ES=3.
REQ-025 Biased exponent <= 0 -> handled per REQ-029/REQ-030 with underflow=1.
REQ-026 Internal exponent arithmetic SHALL be signed and at least 10 bits wide; no wrap for any legal N/ES.

Reset
REQ-027 While rst_n=0:
- All stage valid bits clear; out_valid=0.
- out_float=0 and out_flags=0.
- in_ready=1.
REQ-028 Reset asserted mid-stream discards all in-flight operands; the first accept after deassert behaves as after power-up.

Configuration
REQ-029 Macro POSIT_TO_FLOAT_DENORM_EN defined: underflowing values are shifted into binary32 subnormals with RNE applied after the shift; a result that rounds to zero is a signed zero; inexact is set per REQ-022.
REQ-030 Macro undefined: underflowing values flush to a signed zero, with inexact=1 and underflow=1.

Verification
REQ-031 N=32, ES=2, in_posit=0x40000000 -> 0x3F800000, flags 000, 3 cycles after accept.
REQ-032 N=32, ES=2: 0xC0000000 -> 0xBF800000; 0x00000000 -> 0x00000000; 0x80000000 -> 0x7FC00000 with flags 100.
REQ-033 N=32, ES=2, rounding:
- 0x40000008 -> 0x3F800000 with inexact=1 (tie, round to even).
- 0x40000018 -> 0x3F800002 with inexact=1.
REQ-034 N=32, ES=3, 0x00000001 (2^-240) -> 0x00000000 with flags 011, in both configurations.
REQ-035 N=32, ES=2, backpressure:
- Stream 5 operands with out_ready=0: in_ready drops after 3 accepts.
- out_ready=1: all 5 results emerge in order, each held stable while stalled.
REQ-036 Assert rst_n=0 with 3 operands in flight -> out_valid=0 immediately; after release, no stale result appears.
